// File: rtl/thumb_uart_dump_pkg.sv
// Shared definitions for the thumbnail UART dump sequencer and its neighbours.
// Frame geometry defaults live here so the downsample buffer and the dump agree.
package thumb_uart_dump_pkg;

    localparam int          DEF_COLS = 40;
    localparam int          DEF_ROWS = 30;
    localparam logic [7:0]  DEF_HDR0 = 8'hAA;
    localparam logic [7:0]  DEF_HDR1 = 8'h55;
    localparam int          GAP_W    = 13;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        FETCH = 3'd3,
        LATCH = 3'd4,
        SEND  = 3'd5,
        CSUM  = 3'd6,
        DONE  = 3'd7
    } state_t;

    // Byte z of a word, MSB first.
    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] z);
        logic [7:0] b;
        case (z)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/thumb_uart_dump_if.sv
// Start/status, buffer read port and UART byte port of the dump sequencer.
interface thumb_uart_dump_if;
    logic        start_i;
    logic        busy_o;
    logic        done_o;
    logic [5:0]  rd_x_o;
    logic [4:0]  rd_y_o;
    logic [31:0] rd_data_i;
    logic [7:0]  tx_data_o;
    logic        tx_wr_o;
    logic        tx_busy_i;

    modport master (
        input  start_i, rd_data_i, tx_busy_i,
        output busy_o, done_o, rd_x_o, rd_y_o, tx_data_o, tx_wr_o
    );

    modport slave (
        output start_i, rd_data_i, tx_busy_i,
        input  busy_o, done_o, rd_x_o, rd_y_o, tx_data_o, tx_wr_o
    );
endinterface

// File: rtl/thumb_uart_dump_gap_timer.sv
// Idle-gap timer: counts clocks since the UART went quiet and flags when the
// next byte may be written.
module uart_gap_timer
    import thumb_uart_dump_pkg::*;
#(
    parameter int GAP_CYCLES = 8191
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tx_busy,
    input  logic tx_wr,
    output logic can_send
);

    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYCLES);

    logic [GAP_W-1:0] gap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            gap <= '0;
        else if (tx_busy || tx_wr)
            gap <= '0;
        else if (gap != GAP_MAX)
            gap <= gap + GAP_W'(1);
    end

    assign can_send = (gap == GAP_MAX) && !tx_busy && !tx_wr;

endmodule

// File: rtl/thumb_uart_dump.sv
// Streams one thumbnail frame over the debug UART: sync header, every buffer
// word MSB-first in raster order, then an 8-bit checksum of the pixel bytes.
//
// state | meaning
// IDLE  | waiting for start
// HDR0  | waiting to send first sync byte
// HDR1  | waiting to send second sync byte
// FETCH | address stable, buffer read in flight
// LATCH | capture read data
// SEND  | send the 4 bytes of the latched word
// CSUM  | waiting to send checksum
// DONE  | one-cycle completion pulse
module thumb_uart_dump
    import thumb_uart_dump_pkg::*;
#(
    parameter int         COLS       = DEF_COLS,
    parameter int         ROWS       = DEF_ROWS,
    parameter int         GAP_CYCLES = 8191,
    parameter logic [7:0] HDR0_BYTE  = DEF_HDR0,
    parameter logic [7:0] HDR1_BYTE  = DEF_HDR1
) (
    input  logic               sys_clk_i,
    input  logic               sys_rst_n_i,
    thumb_uart_dump_if.master  bus
);

    localparam logic [5:0] X_LAST = 6'(COLS - 1);
    localparam logic [4:0] Y_LAST = 5'(ROWS - 1);

    state_t      state, state_nxt;
    logic [5:0]  x;
    logic [4:0]  y;
    logic [1:0]  z;
    logic [31:0] word;
    logic [7:0]  csum;
    logic        busy, done, tx_wr;
    logic [7:0]  tx_data;
    logic        can_send, wr_nxt, last_byte, last_word;
    logic [7:0]  byte_nxt;

    uart_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap (
        .clk      (sys_clk_i),
        .rst_n    (sys_rst_n_i),
        .tx_busy  (bus.tx_busy_i),
        .tx_wr    (tx_wr),
        .can_send (can_send)
    );

    assign last_byte = (z == 2'd3);
    assign last_word = (x == X_LAST) && (y == Y_LAST);

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start_i) state_nxt = HDR0;
            HDR0:    if (can_send) state_nxt = HDR1;
            HDR1:    if (can_send) state_nxt = FETCH;
            FETCH:   state_nxt = LATCH;
            LATCH:   state_nxt = SEND;
            SEND:    if (can_send && last_byte) state_nxt = last_word ? CSUM : FETCH;
            CSUM:    if (can_send) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_nxt   = 1'b0;
        byte_nxt = 8'h00;
        case (state)
            HDR0: begin wr_nxt = can_send; byte_nxt = HDR0_BYTE;         end
            HDR1: begin wr_nxt = can_send; byte_nxt = HDR1_BYTE;         end
            SEND: begin wr_nxt = can_send; byte_nxt = byte_sel(word, z); end
            CSUM: begin wr_nxt = can_send; byte_nxt = csum;              end
            default: ;
        endcase
    end

    // The address only moves between words, so the read port never sees a
    // change while the latched word is still being shifted out.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            tx_wr   <= 1'b0;
            tx_data <= 8'h00;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            word    <= '0;
            csum    <= '0;
        end else begin
            tx_wr <= wr_nxt;
            done  <= (state_nxt == DONE);
            if (wr_nxt)
                tx_data <= byte_nxt;
            case (state)
                IDLE: if (bus.start_i) begin
                    busy <= 1'b1;
                    x    <= '0;
                    y    <= '0;
                    csum <= '0;
                end
                LATCH: begin
                    word <= bus.rd_data_i;
                    z    <= '0;
                end
                SEND: if (can_send) begin
                    csum <= csum + byte_nxt;
                    z    <= z + 2'd1;
                    if (last_byte && !last_word) begin
                        if (x == X_LAST) begin
                            x <= '0;
                            y <= y + 5'd1;
                        end else begin
                            x <= x + 6'd1;
                        end
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                    x    <= '0;
                    y    <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o    = busy;
    assign bus.done_o    = done;
    assign bus.tx_wr_o   = tx_wr;
    assign bus.tx_data_o = tx_data;
    assign bus.rd_x_o    = x;
    assign bus.rd_y_o    = y;

endmodule
